// File: rtl/jet_ts_pkg.sv
// Shared definitions for the jet-finding time-slice path. Both the 27:1 slot
// multiplexer and the receive-side collector import this so that slot count,
// slot-select width and slot slicing agree on both ends of the stream.
package jet_ts_pkg;

    localparam int NSLOT  = 27;
    localparam int SLOT_W = 5;

    // Collector frame state: IDLE waits for a slot-0 beat, COLLECT fills slots.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } ts_state_t;

    // Bit offset of slot k inside a packed frame of width-bit slots.
    function automatic int slot_base(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/ts_demux27.sv
// Time-slice frame collector: rebuilds 27-slot frames from a serial stream of
// WIDTH-bit beats. Slots 0..25 land in a capture array; slot 26 goes straight
// into the output bank together with the captured slots, so the completed
// frame appears one cycle after its last beat with a one-cycle out_valid.
//
// Handshake: a beat is accepted on every rising edge where in_valid=1; there
// is no backpressure. in_first marks slot 0 and is ignored while in_valid=0.
// out_valid, err_short and err_orphan are registered one-cycle pulses; at most
// one of them is high in any cycle because each comes from a distinct branch
// of the same beat decision.
module ts_demux27
    import jet_ts_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    output logic [NSLOT*WIDTH-1:0] out_slots,
    output logic                   err_short,
    output logic                   err_orphan
);

    // Index of the final slot; that beat completes the frame instead of
    // being captured.
    localparam logic [SLOT_W-1:0] CNT_LAST = SLOT_W'(NSLOT - 1);

    ts_state_t                state_q, state_d;
    logic [SLOT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]         capture_q [NSLOT-1];
    logic [WIDTH-1:0]         capture_d [NSLOT-1];
    logic [NSLOT*WIDTH-1:0]   out_slots_q, out_slots_d;
    logic                     out_valid_q, out_valid_d;
    logic                     err_short_q, err_short_d;
    logic                     err_orphan_q, err_orphan_d;

    // Frame-open test; counter values past the last slot cannot occur but,
    // if they ever did, the next beat is handled as if no frame were open.
    logic                     frame_open;
    assign frame_open = (state_q == COLLECT) && (cnt_q <= CNT_LAST);

    // Next-state decision for one accepted beat; gaps hold everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_d    = capture_q;
        out_slots_d  = out_slots_q;
        out_valid_d  = 1'b0;
        err_short_d  = 1'b0;
        err_orphan_d = 1'b0;

        if (in_valid) begin
            if (!frame_open) begin
                if (in_first) begin
                    capture_d[0] = in_data;
                    cnt_d        = SLOT_W'(1);
                    state_d      = COLLECT;
                end else begin
                    // Beat with no frame to belong to: dropped.
                    err_orphan_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end
            end else if (in_first) begin
                // Restart: the partial frame is abandoned and this beat
                // becomes slot 0 of the new one, even on the slot-26 beat.
                err_short_d  = 1'b1;
                capture_d[0] = in_data;
                cnt_d        = SLOT_W'(1);
            end else if (cnt_q < CNT_LAST) begin
                for (int k = 0; k < NSLOT - 1; k++) begin
                    if (cnt_q == SLOT_W'(k)) begin
                        capture_d[k] = in_data;
                    end
                end
                cnt_d = cnt_q + SLOT_W'(1);
            end else begin
                // Slot 26: publish the frame without storing the last word.
                for (int k = 0; k < NSLOT - 1; k++) begin
                    out_slots_d[slot_base(k, WIDTH) +: WIDTH] = capture_q[k];
                end
                out_slots_d[slot_base(NSLOT - 1, WIDTH) +: WIDTH] = in_data;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = IDLE;
            end
        end
    end

    // State, capture and output registers; reset clears the output bank too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            capture_q    <= '{default: '0};
            out_slots_q  <= '0;
            out_valid_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            capture_q    <= capture_d;
            out_slots_q  <= out_slots_d;
            out_valid_q  <= out_valid_d;
            err_short_q  <= err_short_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_slots  = out_slots_q;
    assign err_short  = err_short_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_ts_demux27.sv
// Directed bench for ts_demux27: frames are built from known word patterns,
// expected frames are queued as each completing beat is driven and popped
// when the collector reports out_valid.
module tb_ts_demux27;

    localparam int W  = 32;
    localparam int NS = 27;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_first;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic [NS*W-1:0]   out_slots;
    logic              err_short;
    logic              err_orphan;

    int errors;
    int checks;

    // Scoreboard and reference frame state.
    logic [NS*W-1:0] exp_q[$];
    logic [W-1:0]    m_buf [NS];
    int              m_cnt;
    bit              m_open;
    logic [NS*W-1:0] m_last;

    ts_demux27 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_slots  (out_slots),
        .err_short  (err_short),
        .err_orphan (err_orphan)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NS*W-1:0] obs,
                         input logic [NS*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    // Frame whose slot k holds base+k.
    function automatic logic [NS*W-1:0] ramp(input logic [W-1:0] base);
        logic [NS*W-1:0] f;
        for (int k = 0; k < NS; k++) f[k*W +: W] = base + W'(k);
        return f;
    endfunction

    // Drive one cycle (beat or gap), update the reference, check after the edge.
    task automatic cycle(input bit v, input bit f, input logic [W-1:0] d);
        bit exp_v, exp_s, exp_o;
        logic [NS*W-1:0] frame, got;
        exp_v = 0; exp_s = 0; exp_o = 0;
        if (v) begin
            if (!m_open) begin
                if (f) begin
                    m_buf[0] = d; m_cnt = 1; m_open = 1;
                end else begin
                    exp_o = 1;
                end
            end else if (f) begin
                exp_s = 1; m_buf[0] = d; m_cnt = 1;
            end else if (m_cnt < NS - 1) begin
                m_buf[m_cnt] = d; m_cnt++;
            end else begin
                m_buf[NS-1] = d;
                for (int k = 0; k < NS; k++) frame[k*W +: W] = m_buf[k];
                exp_q.push_back(frame);
                m_last = frame;
                exp_v = 1; m_open = 0; m_cnt = 0;
            end
        end
        in_valid = v;
        in_first = f;
        in_data  = d;
        @(posedge clk);
        #1;
        check("out_valid",  NS*W'(out_valid),  NS*W'(exp_v));
        check("err_short",  NS*W'(err_short),  NS*W'(exp_s));
        check("err_orphan", NS*W'(err_orphan), NS*W'(exp_o));
        if (exp_v) begin
            got = exp_q.pop_front();
            check("frame", out_slots, got);
        end
        check("hold", out_slots, m_last);
    endtask

    task automatic send_frame(input logic [W-1:0] base, input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, i == 0, base + W'(i));
            if (gapped && (i == 5 || i == 20)) begin
                for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, $urandom_range(0, 32'hFFFF));
            end
        end
    endtask

    task automatic model_reset();
        m_open = 0; m_cnt = 0; m_last = '0;
        for (int k = 0; k < NS; k++) m_buf[k] = '0;
    endtask

    initial begin
        errors = 0; checks = 0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0;
        #1;
        check("rst_out_valid",  NS*W'(out_valid),  '0);
        check("rst_err_short",  NS*W'(err_short),  '0);
        check("rst_err_orphan", NS*W'(err_orphan), '0);
        check("rst_slots", out_slots, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Orphan beats right after reset.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'(32'h50 + i));
        check("orphan_slots_zero", out_slots, '0);

        // Clean frame.
        send_frame(32'h100, NS, 1'b0);
        check("clean_frame", out_slots, ramp(32'h100));
        cycle(1'b0, 1'b0, '0);

        // Gapped frame then back-to-back frame.
        send_frame(32'h100, NS, 1'b1);
        check("gapped_frame", out_slots, ramp(32'h100));
        send_frame(32'h200, NS, 1'b0);
        check("b2b_frame", out_slots, ramp(32'h200));

        // Short frame restarted by a new slot 0.
        send_frame(32'hA0, 10, 1'b0);
        check("short_no_change", out_slots, ramp(32'h200));
        send_frame(32'hB00, NS, 1'b0);
        check("short_then_full", out_slots, ramp(32'hB00));

        // in_first on the slot-26 beat restarts instead of completing.
        send_frame(32'h500, NS - 1, 1'b0);
        cycle(1'b1, 1'b1, 32'h600);
        check("late_first_no_out", out_slots, ramp(32'hB00));
        for (int i = 1; i < NS; i++) cycle(1'b1, 1'b0, 32'h600 + W'(i));
        check("late_first_frame", out_slots, ramp(32'h600));

        // Reset in the middle of a frame.
        send_frame(32'h300, NS, 1'b0);
        send_frame(32'h400, 14, 1'b0);
        rst_n = 1'b0;
        model_reset();
        in_valid = 1'b0; in_first = 1'b0;
        #1;
        check("midrst_slots_async", out_slots, '0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("midrst_slots",      out_slots, '0);
            check("midrst_out_valid",  NS*W'(out_valid),  '0);
            check("midrst_err_short",  NS*W'(err_short),  '0);
            check("midrst_err_orphan", NS*W'(err_orphan), '0);
        end
        rst_n = 1'b1;
        send_frame(32'h400, NS, 1'b0);
        check("after_rst_frame", out_slots, ramp(32'h400));
        cycle(1'b0, 1'b0, '0);

        check("scoreboard_empty", NS*W'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
